// File: rtl/i1_evt_pkg.sv
// ============================================================================
// i1_evt_pkg : shared widths, event record and sequencer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package i1_evt_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int IDX_W     = $clog2(WIDTH_DEF);
    localparam int TS_W_DEF  = 12;

    typedef struct packed {
        logic [IDX_W-1:0]    idx;
        logic                val;
        logic [TS_W_DEF-1:0] ts;
    } evt_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i1_evt_fifo.sv
// ============================================================================
// i1_evt_fifo : synchronous show-ahead FIFO; head data holds the last popped
//               entry while empty
// Rev 1.0
// ============================================================================
`default_nettype none

module i1_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DW-1:0]            i_din,
    output logic [DW-1:0]            o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [DW-1:0] r_last;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dout  = o_empty ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/i1_evt_sequencer.sv
// ============================================================================
// i1_evt_sequencer : turns bit changes of the decoded vector into queued
//                    {index, value[, timestamp]} events, lowest index first.
// Optional timestamping enabled by defining I1_EVT_TS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module i1_evt_sequencer
    import i1_evt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 8,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_po,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH)-1:0]   out_idx,
    output logic                       out_val,
    output logic [TS_W-1:0]            out_ts,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int IW = $clog2(WIDTH);
`ifdef I1_EVT_TS_EN
    localparam int EW = IW + 1 + TS_W;
`else
    localparam int EW = IW + 1;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_sel_oh;
    logic [IW-1:0]    w_sel_idx;
    logic             w_sel_val;
    logic             w_accept;
    logic             w_push;
    logic             w_can_push;
    logic             w_full;
    logic             w_empty;
    logic [EW-1:0]    w_din;
    logic [EW-1:0]    w_dout;

    assign in_ready   = (r_state == IDLE);
    assign w_accept   = in_valid && in_ready;
    assign w_diff     = in_po ^ r_prev;
    assign out_valid  = !w_empty;
    assign w_can_push = !w_full || out_ready;

    // Isolate the lowest set pending bit; r_prev already holds the new sample
    assign w_sel_oh  = r_pending & (~r_pending + WIDTH'(1));
    assign w_sel_val = r_prev[w_sel_idx];

    always_comb begin
        w_sel_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && (w_diff != '0)) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_can_push) begin
                    w_push = 1'b1;
                    if ((r_pending & ~w_sel_oh) == '0) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_prev    <= in_po;
                r_pending <= w_diff;
            end else if (w_push) begin
                r_pending <= r_pending & ~w_sel_oh;
            end
        end
    end

`ifdef I1_EVT_TS_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_samp_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts      <= '0;
            r_samp_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (w_accept) begin
                r_samp_ts <= r_ts;
            end
        end
    end

    assign w_din                      = {w_sel_idx, w_sel_val, r_samp_ts};
    assign {out_idx, out_val, out_ts} = w_dout;
`else
    assign w_din              = {w_sel_idx, w_sel_val};
    assign {out_idx, out_val} = w_dout;
    assign out_ts             = '0;
`endif

    i1_evt_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (out_ready),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

endmodule

`default_nettype wire

// File: tb/tb_i1_evt_sequencer.sv
// ============================================================================
// tb_i1_evt_sequencer : directed self-checking bench for i1_evt_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i1_evt_sequencer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
`ifdef I1_EVT_TS_EN
    localparam int TS_W  = 4;
`else
    localparam int TS_W  = 12;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [WIDTH-1:0]  in_po;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_idx;
    logic              out_val;
    logic [TS_W-1:0]   out_ts;
    logic [3:0]        fifo_level;

    int n_checks;
    int n_fail;

    i1_evt_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_po      (in_po),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_val    (out_val),
        .out_ts     (out_ts),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_po     = '0;
        out_ready = 1'b0;
        #2;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b level=%0d, want 1 0 0", in_ready, out_valid, fifo_level);
        end
        n_checks++;
        if (out_idx !== 4'd0 || out_val !== 1'b0 || out_ts !== '0) begin
            n_fail++;
            $display("FAIL reset_data: idx=%0d val=%b ts=%0d, want 0 0 0", out_idx, out_val, out_ts);
        end
        step();
        step();
        rst_n = 1'b1;
        // zero sample: no change, no event
        in_valid = 1'b1;
        in_po    = 16'h0000;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL zero_sample: in_ready=%b level=%0d, want 1 0", in_ready, fifo_level);
        end
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_sample_late: out_valid=%b level=%0d in_ready=%b, want 0 0 1", out_valid, fifo_level, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp_idx [3];
        exp_idx[0] = 4'd0;
        exp_idx[1] = 4'd2;
        exp_idx[2] = 4'd15;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_po     = 16'h8005;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
        end
        for (int e = 0; e < 3; e++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx[e] || out_val !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_evt%0d: valid=%b idx=%0d val=%b, want 1 %0d 1", e, out_valid, out_idx, out_val, exp_idx[e]);
            end
            n_checks++;
            if (in_ready !== (e == 2)) begin
                n_fail++;
                $display("FAIL basic_ready%0d: in_ready=%b, want %b", e, in_ready, (e == 2));
            end
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_idx !== 4'd15 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_drained: valid=%b idx=%0d level=%0d, want 0 15 0", out_valid, out_idx, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_po    = 16'h03FF;
        step();
        in_valid = 1'b0;
        repeat (12) step();
        n_checks++;
        if (fifo_level !== 4'd8 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL bp_stall: level=%0d in_ready=%b valid=%b idx=%0d, want 8 0 1 0", fifo_level, in_ready, out_valid, out_idx);
        end
        // full FIFO: pop and push on one edge keeps level at 8
        out_ready = 1'b1;
        step();
        n_checks++;
        if (fifo_level !== 4'd8 || out_idx !== 4'd1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_pp1: level=%0d idx=%0d in_ready=%b, want 8 1 0", fifo_level, out_idx, in_ready);
        end
        step();
        n_checks++;
        if (fifo_level !== 4'd8 || out_idx !== 4'd2 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full_pp2: level=%0d idx=%0d in_ready=%b, want 8 2 1", fifo_level, out_idx, in_ready);
        end
        for (int e = 2; e <= 9; e++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'(e) || out_val !== 1'b1 || fifo_level !== 4'(10 - e)) begin
                n_fail++;
                $display("FAIL bp_drain%0d: valid=%b idx=%0d val=%b level=%0d, want 1 %0d 1 %0d", e, out_valid, out_idx, out_val, fifo_level, e, 10 - e);
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || out_idx !== 4'd9) begin
            n_fail++;
            $display("FAIL bp_end: valid=%b level=%0d idx=%0d, want 0 0 9", out_valid, fifo_level, out_idx);
        end
    endtask

    task automatic test_reset_mid_scan();
        out_ready = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_po    = 16'hFFFF;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        n_checks++;
        if (fifo_level !== 4'd3 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_prefill: level=%0d in_ready=%b, want 3 0", fifo_level, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fifo_level !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 4'd0 || out_val !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_rst: level=%0d valid=%b in_ready=%b idx=%0d val=%b, want 0 0 1 0 0", fifo_level, out_valid, in_ready, out_idx, out_val);
        end
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_po     = 16'h0001;
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_val !== 1'b1 || fifo_level !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_after: valid=%b idx=%0d val=%b level=%0d, want 1 0 1 1", out_valid, out_idx, out_val, fifo_level);
        end
        repeat (4) step();
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_single: valid=%b level=%0d in_ready=%b, want 0 0 1", out_valid, fifo_level, in_ready);
        end
    endtask

    task automatic test_timestamp();
        logic [TS_W-1:0] exp_ts;
`ifdef I1_EVT_TS_EN
        exp_ts = TS_W'(15);
`else
        exp_ts = '0;
`endif
        out_ready = 1'b0;
        do_reset();
        // counter is 0 on release; the 16th edge samples value 15
        repeat (15) step();
        in_valid = 1'b1;
        in_po    = 16'h0001;
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_val !== 1'b1 || out_ts !== exp_ts) begin
            n_fail++;
            $display("FAIL ts_first: valid=%b idx=%0d val=%b ts=%0d, want 1 0 1 %0d", out_valid, out_idx, out_val, out_ts, exp_ts);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        // accept on edge 32: counter wrapped back to 15
        repeat (13) step();
        in_valid = 1'b1;
        in_po    = 16'h0000;
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_val !== 1'b0 || out_ts !== exp_ts) begin
            n_fail++;
            $display("FAIL ts_wrap: valid=%b idx=%0d val=%b ts=%0d, want 1 0 0 %0d", out_valid, out_idx, out_val, out_ts, exp_ts);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_scan();
        test_timestamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
